regfile_wb_arbiter: RTL and testbench

Shares the register file's single write port between the ALU writeback path and the load (memory) writeback path. Drives the registered write-port signals and the writeback-source select. Tracks destinations of outstanding loads in a scoreboard so issue logic can stall on RAW hazards. Sits between the execute/memory stages and the register file, alongside the destination-select mux.

---
 rtl/regfile_wb_arbiter.sv | 127 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register-file write port between ALU and load writeback, with a starvation guard.
// Build with REGFILE_SCOREBOARD_EN defined to include the outstanding-load scoreboard.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned STARVE_LIMIT   = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alu_valid_i,
  output logic                      alu_ready_o,
  input  logic [REG_ADDR_WIDTH-1:0] alu_rd_i,
  input  logic [DATA_WIDTH-1:0]     alu_data_i,
  input  logic                      mem_valid_i,
  output logic                      mem_ready_o,
  input  logic [REG_ADDR_WIDTH-1:0] mem_rd_i,
  input  logic [DATA_WIDTH-1:0]     mem_data_i,
  input  logic                      issue_i,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rd_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_i,
  output logic                      rs1_busy_o,
  output logic                      rs2_busy_o,
  output logic                      rf_we_o,
  output logic [REG_ADDR_WIDTH-1:0] rf_waddr_o,
  output logic [DATA_WIDTH-1:0]     rf_wdata_o,
  output logic                      wb_sel_o
);

  localparam int unsigned NumRegs   = 2 ** REG_ADDR_WIDTH;
  localparam logic [3:0]  StarveMax = 4'(STARVE_LIMIT);

  logic [3:0] starve_q, starve_d;
  logic       starved;
  logic       alu_xfer, mem_xfer;

  logic                      rf_we_d;
  logic [REG_ADDR_WIDTH-1:0] rf_waddr_d;
  logic [DATA_WIDTH-1:0]     rf_wdata_d;
  logic                      wb_sel_d;

  // Ready is a function of the valids and the starve counter only.
  assign starved     = (starve_q == StarveMax);
  assign mem_ready_o = mem_valid_i & ~(alu_valid_i & starved);
  assign alu_ready_o = alu_valid_i & (~mem_valid_i | starved);
  assign alu_xfer    = alu_valid_i & alu_ready_o;
  assign mem_xfer    = mem_valid_i & mem_ready_o;

  always_comb begin
    starve_d = starve_q;
    if (!alu_valid_i || alu_ready_o) begin
      starve_d = '0;
    end else if (starve_q < StarveMax) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_o;
    rf_wdata_d = rf_wdata_o;
    wb_sel_d   = wb_sel_o;
    if (mem_xfer) begin
      rf_we_d    = (mem_rd_i != '0);
      rf_waddr_d = mem_rd_i;
      rf_wdata_d = mem_data_i;
      wb_sel_d   = 1'b1;
    end else if (alu_xfer) begin
      // x0 writes still complete the handshake but never assert the enable.
      rf_we_d    = (alu_rd_i != '0);
      rf_waddr_d = alu_rd_i;
      rf_wdata_d = alu_data_i;
      wb_sel_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q   <= '0;
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
      wb_sel_o   <= 1'b0;
    end else begin
      starve_q   <= starve_d;
      rf_we_o    <= rf_we_d;
      rf_waddr_o <= rf_waddr_d;
      rf_wdata_o <= rf_wdata_d;
      wb_sel_o   <= wb_sel_d;
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [NumRegs-1:0] pending_q, pending_d;

  // Clear first so a same-cycle issue to the same register wins.
  always_comb begin
    pending_d = pending_q;
    if (mem_xfer) begin
      pending_d[mem_rd_i] = 1'b0;
    end
    if (issue_i && (issue_rd_i != '0)) begin
      pending_d[issue_rd_i] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign rs1_busy_o = (rs1_addr_i != '0) & pending_q[rs1_addr_i];
  assign rs2_busy_o = (rs2_addr_i != '0) & pending_q[rs2_addr_i];
`else
  logic unused_sb;
  assign unused_sb  = ^{issue_i, issue_rd_i, rs1_addr_i, rs2_addr_i, NumRegs[0]};
  assign rs1_busy_o = 1'b0;
  assign rs2_busy_o = 1'b0;
`endif

  a_one_ready: assert property (@(posedge clk) disable iff (rst) !(alu_ready_o && mem_ready_o));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: vector table, corner sequences, random vs. model.
module tb_regfile_wb_arbiter;

  localparam int unsigned LIMIT = 3;
`ifdef REGFILE_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic        clk, rst;
  logic        alu_valid_i, alu_ready_o, mem_valid_i, mem_ready_o;
  logic [4:0]  alu_rd_i, mem_rd_i, issue_rd_i, rs1_addr_i, rs2_addr_i;
  logic [31:0] alu_data_i, mem_data_i;
  logic        issue_i, rs1_busy_o, rs2_busy_o;
  logic        rf_we_o, wb_sel_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;

  regfile_wb_arbiter #(
    .DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o),
    .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
    .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o),
    .mem_rd_i(mem_rd_i), .mem_data_i(mem_data_i),
    .issue_i(issue_i), .issue_rd_i(issue_rd_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rs1_busy_o(rs1_busy_o), .rs2_busy_o(rs2_busy_o),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o),
    .rf_wdata_o(rf_wdata_o), .wb_sel_o(wb_sel_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          m_starve;
  bit          m_pend[32];
  logic        m_we, m_sel;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  logic        cur_ar, cur_mr;

  typedef struct {
    logic av; logic [4:0] ard; logic [31:0] ad;
    logic mv; logic [4:0] mrd; logic [31:0] md;
    logic ear; logic emr; logic ewe; logic [4:0] ewa; logic [31:0] ewd; logic esel;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_starve = 0;
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_we = 0; m_sel = 0; m_wa = '0; m_wd = '0;
  endtask

  function automatic logic exp_busy(input logic [4:0] rs);
    return SB && (rs != 0) && m_pend[rs];
  endfunction

  // One clock cycle, entered and left just after a falling edge.
  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                      input logic iss, input logic [4:0] ird,
                      input logic [4:0] r1, input logic [4:0] r2);
    logic ear, emr;
    alu_valid_i = av; alu_rd_i = ard; alu_data_i = ad;
    mem_valid_i = mv; mem_rd_i = mrd; mem_data_i = md;
    issue_i = iss; issue_rd_i = ird; rs1_addr_i = r1; rs2_addr_i = r2;
    #1;
    if (av && mv) begin
      ear = (m_starve == LIMIT); emr = !ear;
    end else begin
      ear = av; emr = mv;
    end
    cur_ar = alu_ready_o; cur_mr = mem_ready_o;
    chk("alu_ready", alu_ready_o, ear);
    chk("mem_ready", mem_ready_o, emr);
    chk("rs1_busy", rs1_busy_o, exp_busy(r1));
    chk("rs2_busy", rs2_busy_o, exp_busy(r2));
    @(posedge clk); #1;
    if (!av || ear) m_starve = 0;
    else if (m_starve < LIMIT) m_starve++;
    if (emr) begin
      m_we = (mrd != 0); m_wa = mrd; m_wd = md; m_sel = 1'b1; m_pend[mrd] = 1'b0;
    end else if (ear) begin
      m_we = (ard != 0); m_wa = ard; m_wd = ad; m_sel = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    if (iss && ird != 0) m_pend[ird] = 1'b1;
    chk("rf_we", rf_we_o, m_we);
    chk("rf_waddr", rf_waddr_o, m_wa);
    chk("rf_wdata", rf_wdata_o, m_wd);
    chk("wb_sel", wb_sel_o, m_sel);
    @(negedge clk);
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    step(0, 0, 0, 0, 0, 0, 0, 0, r1, r2);
  endtask

  initial begin
    vecs[0] = '{1, 5, 32'h1234, 0, 0, 0,          1, 0, 1, 5, 32'h1234, 0};
    vecs[1] = '{0, 0, 0,        1, 10, 32'hdead,  0, 1, 1, 10, 32'hdead, 1};
    vecs[2] = '{0, 0, 0,        0, 0, 0,          0, 0, 0, 10, 32'hdead, 1};
    vecs[3] = '{0, 0, 0,        1, 0, 32'h55,     0, 1, 0, 0, 32'h55, 1};
    vecs[4] = '{1, 0, 32'h77,   0, 0, 0,          1, 0, 0, 0, 32'h77, 0};
    vecs[5] = '{1, 1, 32'h11,   1, 2, 32'h22,     0, 1, 1, 2, 32'h22, 1};
    vecs[6] = '{0, 0, 0,        0, 0, 0,          0, 0, 0, 2, 32'h22, 1};

    rst = 1'b1;
    alu_valid_i = 0; alu_rd_i = 0; alu_data_i = 0;
    mem_valid_i = 0; mem_rd_i = 0; mem_data_i = 0;
    issue_i = 0; issue_rd_i = 0; rs1_addr_i = 0; rs2_addr_i = 0;
    model_reset();
    #2;
    chk("reset_we", rf_we_o, 0);
    chk("reset_waddr", rf_waddr_o, 0);
    chk("reset_wdata", rf_wdata_o, 0);
    chk("reset_sel", wb_sel_o, 0);
    @(negedge clk);
    rst = 1'b0;

    // Vector table
    for (int i = 0; i < 7; i++) begin
      step(vecs[i].av, vecs[i].ard, vecs[i].ad, vecs[i].mv, vecs[i].mrd, vecs[i].md,
           0, 0, 0, 0);
      chk("vec_alu_ready", cur_ar, vecs[i].ear);
      chk("vec_mem_ready", cur_mr, vecs[i].emr);
      chk("vec_we", rf_we_o, vecs[i].ewe);
      chk("vec_waddr", rf_waddr_o, vecs[i].ewa);
      chk("vec_wdata", rf_wdata_o, vecs[i].ewd);
      chk("vec_sel", wb_sel_o, vecs[i].esel);
    end

    // Starvation: MEM wins three cycles, ALU the fourth, MEM again the fifth.
    for (int i = 0; i < 5; i++) begin
      step(1, 6, 32'ha0 + i, 1, 8, 32'hb0 + i, 0, 0, 0, 0);
      chk("starve_alu_ready", cur_ar, (i == 3));
      chk("starve_sel", wb_sel_o, (i != 3));
    end
    idle(0, 0);

    // Scoreboard set/clear
    step(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    chk("sb_busy_set", rs1_busy_o, SB);
    step(0, 0, 0, 1, 7, 32'hc7, 0, 0, 7, 0);
    chk("sb_clear_we", rf_we_o, 1);
    chk("sb_clear_addr", rf_waddr_o, 7);
    chk("sb_busy_clear", rs1_busy_o, 0);

    // Same-cycle issue and clear: set wins.
    step(0, 0, 0, 0, 0, 0, 1, 9, 0, 9);
    step(0, 0, 0, 1, 9, 32'hc9, 1, 9, 0, 9);
    chk("sb_set_wins", rs2_busy_o, SB);
    step(0, 0, 0, 1, 9, 32'hd9, 0, 0, 9, 0);
    chk("sb_busy_x0", rs1_busy_o, 0);
    chk("sb_x0_addr", 64'(rs2_addr_i), 0);

    // Asynchronous reset mid-stream with pending 3 and 7.
    step(0, 0, 0, 0, 0, 0, 1, 3, 0, 0);
    step(1, 4, 32'habc, 0, 0, 0, 1, 7, 0, 0);
    rs1_addr_i = 3; rs2_addr_i = 7;
    alu_valid_i = 1; alu_rd_i = 5; alu_data_i = 32'h99;
    #1;
    chk("pre_rst_busy1", rs1_busy_o, SB);
    chk("pre_rst_busy2", rs2_busy_o, SB);
    chk("pre_rst_we", rf_we_o, 1);
    rst = 1'b1;
    #1;
    chk("rst_we", rf_we_o, 0);
    chk("rst_waddr", rf_waddr_o, 0);
    chk("rst_wdata", rf_wdata_o, 0);
    chk("rst_sel", wb_sel_o, 0);
    chk("rst_busy1", rs1_busy_o, 0);
    chk("rst_busy2", rs2_busy_o, 0);
    model_reset();
    alu_valid_i = 0;
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic against the model; small register range forces collisions.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 1), 5'($urandom_range(0, 15)), $urandom,
           $urandom_range(0, 1), 5'($urandom_range(0, 15)), $urandom,
           $urandom_range(0, 1), 5'($urandom_range(0, 15)),
           5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
